// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
// Holds the FSM state encoding, the aligned bundle layout and the block-address helper.
package fetch_pkg;

    localparam int FETCH_WIDTH = 4;
    localparam int BLOCK_BYTES = 16;
    localparam int OFF_W       = 2;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef logic [FETCH_WIDTH-1:0][31:0] inst_vec_t;

    typedef struct packed {
        inst_vec_t   inst;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] pc;
    } bundle_t;

    // Clears the offset-within-block bits of a byte address.
    function automatic logic [31:0] block_addr(input logic [31:0] a);
        return a & ~(32'(BLOCK_BYTES) - 32'd1);
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Signal bundle between the fetch unit, the instruction cache and the instruction buffer.
// The master side is the fetch unit; the slave side is its environment.
interface fetch_if;

    logic        icache_req_valid;
    logic        icache_req_ready;
    logic [31:0] icache_req_addr;

    logic        icache_resp_valid;
    logic [31:0] icache_resp_inst_0;
    logic [31:0] icache_resp_inst_1;
    logic [31:0] icache_resp_inst_2;
    logic [31:0] icache_resp_inst_3;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_bits_icache_inst_0;
    logic [31:0] out_bits_icache_inst_1;
    logic [31:0] out_bits_icache_inst_2;
    logic [31:0] out_bits_icache_inst_3;
    logic [31:0] out_bits_icache_addr;
    logic [2:0]  out_bits_icache_size;
    logic [31:0] out_bits_pc;

    logic        back_pressure;
    logic        redirect_valid;
    logic [31:0] redirect_target;

    modport master (
        output icache_req_valid,
        input  icache_req_ready,
        output icache_req_addr,
        input  icache_resp_valid,
        input  icache_resp_inst_0,
        input  icache_resp_inst_1,
        input  icache_resp_inst_2,
        input  icache_resp_inst_3,
        output out_valid,
        input  out_ready,
        output out_bits_icache_inst_0,
        output out_bits_icache_inst_1,
        output out_bits_icache_inst_2,
        output out_bits_icache_inst_3,
        output out_bits_icache_addr,
        output out_bits_icache_size,
        output out_bits_pc,
        input  back_pressure,
        input  redirect_valid,
        input  redirect_target
    );

    modport slave (
        input  icache_req_valid,
        output icache_req_ready,
        input  icache_req_addr,
        output icache_resp_valid,
        output icache_resp_inst_0,
        output icache_resp_inst_1,
        output icache_resp_inst_2,
        output icache_resp_inst_3,
        input  out_valid,
        output out_ready,
        input  out_bits_icache_inst_0,
        input  out_bits_icache_inst_1,
        input  out_bits_icache_inst_2,
        input  out_bits_icache_inst_3,
        input  out_bits_icache_addr,
        input  out_bits_icache_size,
        input  out_bits_pc,
        output back_pressure,
        output redirect_valid,
        output redirect_target
    );

endinterface

// File: rtl/fetch_align.sv
// Rotates a fetched block so the word at the fetch offset lands in slot 0.
// Slots past the end of the block are zero-filled; size counts the remaining valid slots.
module fetch_align
    import fetch_pkg::*;
(
    input  inst_vec_t          words_in,
    input  logic [OFF_W-1:0]   off,
    output inst_vec_t          words_out,
    output logic [2:0]         size
);

    logic [OFF_W:0] src;

    always_comb begin
        words_out = '0;
        src       = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            src = {1'b0, OFF_W'(i)} + {1'b0, off};
            // A carry out of the offset sum means the source word lies beyond this block.
            if (!src[OFF_W]) begin
                words_out[OFF_W'(i)] = words_in[src[OFF_W-1:0]];
            end
        end
        size = 3'(FETCH_WIDTH) - 3'(off);
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: owns the fetch PC, issues one block request at a time,
// aligns the returned block and holds the bundle until the instruction buffer takes it.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic     clock,
    input  logic     reset,
    fetch_if.master  io
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        drop_q, drop_d;
    bundle_t     bundle_q, bundle_d;

    inst_vec_t   resp_words;
    inst_vec_t   aligned_words;
    logic [2:0]  aligned_size;
    logic        req_fire;
    logic        out_fire;
    logic        unused_target_lsb;

    assign resp_words = {io.icache_resp_inst_3, io.icache_resp_inst_2,
                         io.icache_resp_inst_1, io.icache_resp_inst_0};

    // Redirect targets are word aligned; the low bits are don't-care.
    assign unused_target_lsb = ^io.redirect_target[1:0];

    fetch_align u_align (
        .words_in  (resp_words),
        .off       (pc_q[3:2]),
        .words_out (aligned_words),
        .size      (aligned_size)
    );

    // A redirect suppresses both the request and the bundle in the cycle it arrives.
    assign io.icache_req_valid = !reset && (state_q == REQ) &&
                                 !io.back_pressure && !io.redirect_valid;
    assign io.icache_req_addr  = block_addr(pc_q);
    assign io.out_valid        = (state_q == HOLD) && !io.redirect_valid;

    assign req_fire = io.icache_req_valid && io.icache_req_ready;
    assign out_fire = io.out_valid && io.out_ready;

    assign io.out_bits_icache_inst_0 = bundle_q.inst[0];
    assign io.out_bits_icache_inst_1 = bundle_q.inst[1];
    assign io.out_bits_icache_inst_2 = bundle_q.inst[2];
    assign io.out_bits_icache_inst_3 = bundle_q.inst[3];
    assign io.out_bits_icache_addr   = bundle_q.addr;
    assign io.out_bits_icache_size   = bundle_q.size;
    assign io.out_bits_pc            = bundle_q.pc;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        drop_d   = drop_q;
        bundle_d = bundle_q;

        unique case (state_q)
            REQ: begin
                if (req_fire) begin
                    state_d = WAIT;
                end
            end

            WAIT: begin
                if (io.redirect_valid) begin
                    // A response landing with the redirect is simply discarded; otherwise
                    // remember to discard the one still in flight.
                    if (io.icache_resp_valid) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end else if (io.icache_resp_valid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        bundle_d.inst = aligned_words;
                        bundle_d.addr = block_addr(pc_q);
                        bundle_d.size = aligned_size;
                        bundle_d.pc   = pc_q;
                        state_d       = HOLD;
                    end
                end
            end

            HOLD: begin
                if (io.redirect_valid) begin
                    state_d = REQ;
                end else if (out_fire) begin
                    pc_d    = block_addr(pc_q) + 32'(BLOCK_BYTES);
                    state_d = REQ;
                end
            end

            default: begin
                state_d = REQ;
            end
        endcase

        if (io.redirect_valid) begin
            pc_d = {io.redirect_target[31:2], 2'b00};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= REQ;
            pc_q     <= RESET_PC;
            drop_q   <= 1'b0;
            bundle_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            drop_q   <= drop_d;
            bundle_q <= bundle_d;
        end
    end

    // Only one request may be outstanding, and a presented bundle always has 1..4 slots.
    a_single_outstanding: assert property (@(posedge clock) disable iff (reset)
        (state_q != REQ) |-> !io.icache_req_valid);

    a_size_range: assert property (@(posedge clock) disable iff (reset)
        io.out_valid |-> (io.out_bits_icache_size inside {[3'd1:3'd4]}));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small latency-configurable cache responder.
// Cache words are the word address with bit 0 set, so expected slots are easy to hand-derive.
module tb_fetch_unit;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   lat   = 1;
    int   n_chk = 0;
    int   n_pass = 0;
    logic [31:0] rsp_addr;

    fetch_if io ();

    fetch_unit #(.RESET_PC(32'h8000_0000)) dut (
        .clock (clock),
        .reset (reset),
        .io    (io)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic wait_out(input string tag, output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!io.out_valid && n < 20);
        if (!io.out_valid) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic chk_bundle(input string tag, input logic [31:0] pc, input logic [31:0] addr,
                              input logic [31:0] size, input logic [31:0] i0,
                              input logic [31:0] i1, input logic [31:0] i2,
                              input logic [31:0] i3);
        chk({tag, "_pc"},   io.out_bits_pc, pc);
        chk({tag, "_addr"}, io.out_bits_icache_addr, addr);
        chk({tag, "_size"}, 32'(io.out_bits_icache_size), size);
        chk({tag, "_i0"},   io.out_bits_icache_inst_0, i0);
        chk({tag, "_i1"},   io.out_bits_icache_inst_1, i1);
        chk({tag, "_i2"},   io.out_bits_icache_inst_2, i2);
        chk({tag, "_i3"},   io.out_bits_icache_inst_3, i3);
    endtask

    // Single-outstanding cache: answers each accepted request after lat cycles.
    initial begin
        io.icache_resp_valid  = 1'b0;
        io.icache_resp_inst_0 = '0;
        io.icache_resp_inst_1 = '0;
        io.icache_resp_inst_2 = '0;
        io.icache_resp_inst_3 = '0;
        forever begin
            @(negedge clock);
            if (io.icache_req_valid && io.icache_req_ready) begin
                rsp_addr = io.icache_req_addr;
                @(posedge clock);
                repeat (lat - 1) @(posedge clock);
                #1;
                io.icache_resp_valid  = 1'b1;
                io.icache_resp_inst_0 = rsp_addr | 32'h1;
                io.icache_resp_inst_1 = rsp_addr | 32'h5;
                io.icache_resp_inst_2 = rsp_addr | 32'h9;
                io.icache_resp_inst_3 = rsp_addr | 32'hD;
                @(posedge clock);
                #1;
                io.icache_resp_valid  = 1'b0;
            end
        end
    end

    initial begin
        int n;
        io.icache_req_ready = 1'b1;
        io.out_ready        = 1'b1;
        io.back_pressure    = 1'b0;
        io.redirect_valid   = 1'b0;
        io.redirect_target  = '0;

        repeat (2) @(negedge clock);
        chk("rst_req_valid", 32'(io.icache_req_valid), 32'd0);
        chk("rst_out_valid", 32'(io.out_valid), 32'd0);
        chk("rst_out_pc",    io.out_bits_pc, 32'd0);
        chk("rst_out_size",  32'(io.out_bits_icache_size), 32'd0);

        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        chk("first_req_valid", 32'(io.icache_req_valid), 32'd1);
        chk("first_req_addr",  io.icache_req_addr, 32'h8000_0000);

        wait_out("b0", n);
        chk_bundle("b0", 32'h8000_0000, 32'h8000_0000, 32'd4,
                   32'h8000_0001, 32'h8000_0005, 32'h8000_0009, 32'h8000_000D);
        @(negedge clock);
        chk("b0_next_req_addr", io.icache_req_addr, 32'h8000_0010);
        chk("b0_next_req_valid", 32'(io.icache_req_valid), 32'd1);
        wait_out("b1", n);
        // REQ, WAIT, HOLD: one bundle every third cycle.
        chk("b1_gap", 32'(n), 32'd2);
        chk("b1_pc",  io.out_bits_pc, 32'h8000_0010);

        // Redirect while in REQ, then a 2-cycle cache.
        @(posedge clock); #1;
        lat = 2;
        io.redirect_valid  = 1'b1;
        io.redirect_target = 32'h8000_0108;
        @(negedge clock);
        chk("redir_req_suppressed", 32'(io.icache_req_valid), 32'd0);
        @(posedge clock); #1 io.redirect_valid = 1'b0;
        @(negedge clock);
        chk("redir_req_valid", 32'(io.icache_req_valid), 32'd1);
        chk("redir_req_addr",  io.icache_req_addr, 32'h8000_0100);
        wait_out("b2", n);
        chk_bundle("b2", 32'h8000_0108, 32'h8000_0100, 32'd2,
                   32'h8000_0109, 32'h8000_010D, 32'h0, 32'h0);
        @(negedge clock);
        chk("b2_next_req_addr", io.icache_req_addr, 32'h8000_0110);

        // Redirect in WAIT before the response: the late response must be dropped.
        @(posedge clock); #1;
        io.redirect_valid  = 1'b1;
        io.redirect_target = 32'h9000_0000;
        io.out_ready       = 1'b0;
        @(negedge clock);
        chk("wait_redir_out0", 32'(io.out_valid), 32'd0);
        @(posedge clock); #1 io.redirect_valid = 1'b0;
        @(negedge clock);
        chk("wait_drop_out1", 32'(io.out_valid), 32'd0);
        @(negedge clock);
        chk("wait_drop_out2", 32'(io.out_valid), 32'd0);
        chk("wait_drop_req_valid", 32'(io.icache_req_valid), 32'd1);
        chk("wait_drop_req_addr",  io.icache_req_addr, 32'h9000_0000);

        // Hold the bundle for five cycles with the buffer not ready.
        wait_out("b3", n);
        chk_bundle("b3", 32'h9000_0000, 32'h9000_0000, 32'd4,
                   32'h9000_0001, 32'h9000_0005, 32'h9000_0009, 32'h9000_000D);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk($sformatf("stall%0d_out_valid", i), 32'(io.out_valid), 32'd1);
            chk($sformatf("stall%0d_pc", i), io.out_bits_pc, 32'h9000_0000);
            chk($sformatf("stall%0d_req_valid", i), 32'(io.icache_req_valid), 32'd0);
        end
        @(posedge clock); #1;
        io.out_ready     = 1'b1;
        io.back_pressure = 1'b1;
        @(negedge clock);
        chk("bp_hold_delivered", 32'(io.out_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk($sformatf("bp%0d_req_valid", i), 32'(io.icache_req_valid), 32'd0);
        end
        @(posedge clock); #1 io.back_pressure = 1'b0;
        @(negedge clock);
        chk("bp_release_req_valid", 32'(io.icache_req_valid), 32'd1);
        chk("bp_release_req_addr",  io.icache_req_addr, 32'h9000_0010);

        // Redirect in HOLD coinciding with a ready buffer.
        @(posedge clock);
        @(posedge clock);
        @(posedge clock); #1;
        io.redirect_valid  = 1'b1;
        io.redirect_target = 32'hFFFF_FFF0;
        @(negedge clock);
        chk("hold_redir_out_valid", 32'(io.out_valid), 32'd0);
        @(posedge clock); #1 io.redirect_valid = 1'b0;
        @(negedge clock);
        chk("hold_redir_req_addr", io.icache_req_addr, 32'hFFFF_FFF0);

        // Top-of-memory block: next address wraps to zero.
        wait_out("b4", n);
        chk_bundle("b4", 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'd4,
                   32'hFFFF_FFF1, 32'hFFFF_FFF5, 32'hFFFF_FFF9, 32'hFFFF_FFFD);
        @(negedge clock);
        chk("wrap_req_valid", 32'(io.icache_req_valid), 32'd1);
        chk("wrap_req_addr",  io.icache_req_addr, 32'h0000_0000);

        // Reset mid-WAIT; the response that follows arrives in REQ and is ignored.
        @(posedge clock); #1;
        reset            = 1'b1;
        io.back_pressure = 1'b1;
        @(negedge clock);
        chk("midrst_req_valid", 32'(io.icache_req_valid), 32'd0);
        chk("midrst_out_valid", 32'(io.out_valid), 32'd0);
        chk("midrst_out_pc",    io.out_bits_pc, 32'd0);
        chk("midrst_out_size",  32'(io.out_bits_icache_size), 32'd0);
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        chk("late_resp_out0", 32'(io.out_valid), 32'd0);
        @(negedge clock);
        chk("late_resp_out1", 32'(io.out_valid), 32'd0);
        @(posedge clock); #1 io.back_pressure = 1'b0;
        @(negedge clock);
        chk("postrst_req_addr", io.icache_req_addr, 32'h8000_0000);
        wait_out("b5", n);
        chk("b5_pc",   io.out_bits_pc, 32'h8000_0000);
        chk("b5_size", 32'(io.out_bits_icache_size), 32'd4);

        // Redirect in WAIT together with the response, 1-cycle cache.
        lat = 1;
        @(posedge clock);
        @(posedge clock); #1;
        io.redirect_valid  = 1'b1;
        io.redirect_target = 32'h8000_0207;
        @(negedge clock);
        chk("resp_redir_out0", 32'(io.out_valid), 32'd0);
        @(posedge clock); #1 io.redirect_valid = 1'b0;
        @(negedge clock);
        chk("resp_redir_out1", 32'(io.out_valid), 32'd0);
        chk("resp_redir_req_addr", io.icache_req_addr, 32'h8000_0200);
        wait_out("b6", n);
        chk_bundle("b6", 32'h8000_0204, 32'h8000_0200, 32'd3,
                   32'h8000_0205, 32'h8000_0209, 32'h8000_020D, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front-end that sits directly upstream of the instruction buffer. It owns the fetch PC and issues one 16-byte-aligned block request at a time to the instruction cache. It aligns the returned four instructions so the instruction at PC lands in slot 0, and presents a bundle with PC and valid count to the buffer. It throttles on buffer back-pressure and discards in-flight or held work on a redirect.

## Interface
- RESET_PC, 32'h8000_0000, first fetch address after reset (bits [1:0] must be 0)
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- io_icache_req_valid  out  1  block request valid
- io_icache_req_ready  in  1  cache accepts request
- io_icache_req_addr  out  32  block address, bits [3:0] = 0
- io_icache_resp_valid  in  1  one-cycle response pulse; always accepted, no ready
- io_icache_resp_inst_0..3  in  32 each  words at block offsets 0,4,8,12
- io_out_valid  out  1  bundle valid to buffer
- io_out_ready  in  1  buffer accepts bundle
- io_out_bits_icache_inst_0..3  out  32 each  aligned instructions, slot 0 = inst at pc
- io_out_bits_icache_addr  out  32  block address of bundle
- io_out_bits_icache_size  out  3  number of valid slots, 1..4
- io_out_bits_pc  out  32  pc of slot 0
- io_back_pressure  in  1  buffer nearly full; suppresses new requests
- io_redirect_valid  in  1  flush/redirect pulse, same cycle as buffer io_flush
- io_redirect_target  in  32  new fetch pc; bits [1:0] ignored (treated as 0)

## Operation
- States: REQ, WAIT, HOLD. Registers: pc, state, drop, output bundle.
- REQ: io_icache_req_valid = !io_back_pressure && !io_redirect_valid; addr = {pc[31:4],4'h0}. On req fire -> WAIT.
- WAIT: on resp_valid with drop=0, capture the bundle and go to HOLD. With off = pc[3:2], slot i = resp_inst[off+i] for i < 4-off. Slots i >= 4-off are 0. size = 4-off (3-bit; off=0 gives 4). pc_out = pc. addr_out = block address.
- WAIT: on resp_valid with drop=1, discard the response, clear drop, go to REQ.
- HOLD: io_out_valid=1, bundle stable. On out fire: pc <= {pc[31:4],4'h0} + 16 (wraps modulo 2^32), -> REQ.
- Redirect, any state: pc <= {target[31:2],2'b00}. Takes priority over every concurrent event.
  - REQ: request suppressed this cycle, stay REQ.
  - WAIT without same-cycle resp: set drop=1, stay WAIT.
  - WAIT with same-cycle resp: response discarded, drop stays 0, -> REQ.
  - HOLD: io_out_valid forced 0 that cycle, bundle dropped, -> REQ. A same-cycle out fire is void; the buffer flushes on the same pulse.
- Exactly one request outstanding at a time; no new request until the previous response has arrived or been dropped.

## Timing
- Reset values: state=REQ, pc=RESET_PC, drop=0, io_out_valid=0, io_icache_req_valid=0 while reset is asserted, output bundle registers 0.
- Request issue is combinational from state; req fire cycle N, resp earliest N+1.
- io_out_valid is asserted the cycle after resp capture (registered output).
- Out fire in cycle M: io_icache_req_valid can be high in M+1.
- Steady-state throughput: one bundle per 3 cycles with a 1-cycle cache.
- io_back_pressure is sampled only in REQ; a held bundle is still delivered while it is high.
- Reset asserted mid-operation: returns to reset values immediately. A late resp_valid after reset deasserts, arriving while in REQ, is ignored.

## Structure
- Package fetch_pkg: state enum {REQ, WAIT, HOLD}, FETCH_WIDTH=4, BLOCK_BYTES=16, OFF_W=2, bundle struct {inst[4], addr, size, pc}.
- Sub-module fetch_align: combinational rotate/zero-fill of the 4 response words by off, plus size = 4-off.
- Top level holds the FSM, pc, drop flag and output register.

## Test plan
- Reset, ready always 1, 1-cycle cache: first req addr 0x8000_0000, bundle pc 0x8000_0000, size 4. Next req addr 0x8000_0010.
- Redirect to 0x8000_0108 with 2-cycle cache and ready=1: req addr 0x8000_0100. Bundle inst_0=resp_inst_2, inst_1=resp_inst_3, inst_2/3=0, size 2, pc 0x8000_0108. Next pc 0x8000_0110.
- Redirect to 0x9000_0000 while in WAIT, resp one cycle later: that resp produces no io_out_valid. Next req addr 0x9000_0000.
- io_out_ready=0 for 5 cycles in HOLD: bundle stable and no new request. io_back_pressure=1 in REQ: req_valid stays 0 until it drops.
- Redirect in HOLD coincident with io_out_ready=1: io_out_valid=0 that cycle, and the next req uses the target block.
- pc=0xFFFF_FFF0, response delivered: next req addr wraps to 0x0000_0000.
